// File: rtl/shift_seq_pkg.sv
// Shared op-codes, FSM state type and op classification for the shift sequencer.
package shift_seq_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_PASS = 3'b000;
  localparam logic [OP_W-1:0] OP_SHL  = 3'b001;
  localparam logic [OP_W-1:0] OP_SHR  = 3'b010;
  localparam logic [OP_W-1:0] OP_SAR  = 3'b011;
  localparam logic [OP_W-1:0] OP_ROL  = 3'b100;
  localparam logic [OP_W-1:0] OP_ROR  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // True for op-codes that move bits; 000/110/111 pass the operand through.
  function automatic logic op_shifts(input logic [OP_W-1:0] op);
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_SAR) ||
           (op == OP_ROL) || (op == OP_ROR);
  endfunction

endpackage

// File: rtl/shift_sequencer_step.sv
// shift_step: one single-position shift/rotate of a word, plus the bit moved out.
module shift_step
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_word,
  input  logic [OP_W-1:0]  i_op,
  output logic [WIDTH-1:0] o_word_c,
  output logic             o_carry_c
);

  // Select the one-step result; non-shifting op-codes leave the word untouched.
  always_comb begin
    o_word_c  = i_word;
    o_carry_c = 1'b0;
    case (i_op)
      OP_SHL: begin
        o_word_c  = {i_word[WIDTH-2:0], 1'b0};
        o_carry_c = i_word[WIDTH-1];
      end
      OP_SHR: begin
        o_word_c  = {1'b0, i_word[WIDTH-1:1]};
        o_carry_c = i_word[0];
      end
      OP_SAR: begin
        o_word_c  = {i_word[WIDTH-1], i_word[WIDTH-1:1]};
        o_carry_c = i_word[0];
      end
      OP_ROL: begin
        o_word_c  = {i_word[WIDTH-2:0], i_word[WIDTH-1]};
        o_carry_c = i_word[WIDTH-1];
      end
      OP_ROR: begin
        o_word_c  = {i_word[0], i_word[WIDTH-1:1]};
        o_carry_c = i_word[0];
      end
      default: begin
        o_word_c  = i_word;
        o_carry_c = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: accepts one command, applies one shift step per clock, then
// holds the result until the consumer takes it.
// Optional build macro SHIFT_SEQ_FLAGS_EN adds res_carry / res_zero outputs.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OP_W-1:0]  cmd_op,
  input  logic [CNT_W-1:0] cmd_amt,
  input  logic [WIDTH-1:0] cmd_word,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_word,
  output logic             busy
`ifdef SHIFT_SEQ_FLAGS_EN
  ,
  output logic             res_carry,
  output logic             res_zero
`endif
);

  logic [1:0]       r_rst_sync;
  logic             w_rst_n;
  state_t           r_state;
  logic [OP_W-1:0]  r_op;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_word;
  logic             r_res_valid;
  logic             r_cmd_ready;
  logic             r_busy;
  logic [WIDTH-1:0] w_step_word;
  logic             w_step_carry;
`ifdef SHIFT_SEQ_FLAGS_EN
  logic             r_carry;
  logic             r_zero;
`endif

  // Reset asserts immediately and releases on a clock edge two cycles later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  shift_step #(.WIDTH(WIDTH)) u_step (
    .i_word    (r_word),
    .i_op      (r_op),
    .o_word_c  (w_step_word),
    .o_carry_c (w_step_carry)
  );

  // Sequencer FSM: IDLE accepts, SHIFT steps once per clock, DONE holds the result.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_PASS;
      r_count     <= '0;
      r_word      <= '0;
      r_res_valid <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
`ifdef SHIFT_SEQ_FLAGS_EN
      r_carry     <= 1'b0;
      r_zero      <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_word      <= cmd_word;
            r_op        <= cmd_op;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
`ifdef SHIFT_SEQ_FLAGS_EN
            r_carry     <= 1'b0;
`endif
            if (op_shifts(cmd_op) && (cmd_amt != '0)) begin
              r_count <= cmd_amt;
              r_state <= ST_SHIFT;
            end else begin
              r_count     <= '0;
              r_res_valid <= 1'b1;
              r_state     <= ST_DONE;
`ifdef SHIFT_SEQ_FLAGS_EN
              r_zero      <= (cmd_word == '0);
`endif
            end
          end
        end
        ST_SHIFT: begin
          r_word  <= w_step_word;
          r_count <= r_count - CNT_W'(1);
`ifdef SHIFT_SEQ_FLAGS_EN
          r_carry <= w_step_carry;
`endif
          if (r_count == CNT_W'(1)) begin
            r_res_valid <= 1'b1;
            r_state     <= ST_DONE;
`ifdef SHIFT_SEQ_FLAGS_EN
            r_zero      <= (w_step_word == '0);
`endif
          end
        end
        ST_DONE: begin
          // Returning to IDLE first keeps a waiting command from being taken on this edge.
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_res_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign res_valid = r_res_valid;
  assign res_word  = r_word;
  assign busy      = r_busy;
`ifdef SHIFT_SEQ_FLAGS_EN
  assign res_carry = r_carry;
  assign res_zero  = r_zero;
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: driver queues expected results, a
// monitor checks each result, its latency and its stability until consumed.
module tb_shift_sequencer;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [2:0]       cmd_op = 3'b000;
  logic [CNT_W-1:0] cmd_amt = '0;
  logic [WIDTH-1:0] cmd_word = '0;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [WIDTH-1:0] res_word;
  logic             busy;
`ifdef SHIFT_SEQ_FLAGS_EN
  logic             res_carry;
  logic             res_zero;
`endif

  typedef struct {
    logic [WIDTH-1:0] word;
    logic             carry;
    int               lat;
    int               hold;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  shift_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_amt   (cmd_amt),
    .cmd_word  (cmd_word),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_word  (res_word),
    .busy      (busy)
`ifdef SHIFT_SEQ_FLAGS_EN
    ,
    .res_carry (res_carry),
    .res_zero  (res_zero)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Queue the expected result, then offer the command until it is accepted.
  task automatic issue(input logic [2:0] op, input logic [2:0] amt, input logic [3:0] word,
                       input logic [3:0] ew, input logic ec, input int lat, input int hold,
                       input bit pulse);
    exp_t e;
    int   guard;
    e.word = ew; e.carry = ec; e.lat = lat; e.hold = hold;
    exp_q.push_back(e);
    @(negedge clk);
    cmd_op = op; cmd_amt = amt; cmd_word = word; cmd_valid = 1'b1;
    guard = 0;
    while (!cmd_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL accept_timeout: cmd_ready=%0b, required 1", cmd_ready);
      cmd_valid = 1'b0;
      e = exp_q.pop_back();
      return;
    end
    @(posedge clk);
    acc_q.push_back(cyc);
    #1;
    cmd_valid = 1'b0;
    cmd_word  = ~word;
    if (pulse) begin
      @(negedge clk);
      @(negedge clk);
      chk("ready_while_busy", 32'(cmd_ready), 0);
      cmd_valid = 1'b1; cmd_op = 3'b001; cmd_amt = 3'd1; cmd_word = 4'hF;
      @(negedge clk);
      cmd_valid = 1'b0;
    end
  endtask

  // Wait for every queued result to be consumed and the block to go idle.
  task automatic flush();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || busy || res_valid) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    chk("flush_idle", 32'(busy), 0);
    @(negedge clk);
  endtask

  // Monitor: compare each presented result, hold it for the requested cycles, consume.
  initial begin
    exp_t             e;
    int               acc;
    logic [WIDTH-1:0] w0;
    forever begin
      @(negedge clk);
      if (rst_n && res_valid) begin
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_result: got res_word=%0h, required no result", res_word);
          res_ready = 1'b1;
          @(negedge clk);
          res_ready = 1'b0;
        end else begin
          e   = exp_q.pop_front();
          acc = acc_q.pop_front();
          chk("res_word", 32'(res_word), 32'(e.word));
          chk("latency", 32'(cyc - acc - 1), 32'(e.lat));
`ifdef SHIFT_SEQ_FLAGS_EN
          chk("res_carry", 32'(res_carry), 32'(e.carry));
          chk("res_zero", 32'(res_zero), 32'(e.word == 4'h0));
`endif
          w0 = res_word;
          for (int h = 0; h < e.hold; h++) begin
            @(negedge clk);
            chk("hold_valid", 32'(res_valid), 1);
            chk("hold_word", 32'(res_word), 32'(w0));
            chk("hold_busy", 32'(busy), 1);
          end
          res_ready = 1'b1;
          @(negedge clk);
          res_ready = 1'b0;
          chk("post_valid", 32'(res_valid), 0);
          chk("post_busy", 32'(busy), 0);
          chk("post_cmd_ready", 32'(cmd_ready), 1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on reset
    repeat (3) @(negedge clk);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_res_word", 32'(res_word), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);

    //    op      amt   word    exp     carry lat hold pulse
    issue(3'b001, 3'd1, 4'b1011, 4'b0110, 1'b1, 1, 0, 1'b0); // SHL
    issue(3'b011, 3'd2, 4'b1000, 4'b1110, 1'b0, 2, 0, 1'b0); // SAR
    issue(3'b100, 3'd5, 4'b0011, 4'b0110, 1'b0, 5, 0, 1'b1); // ROL with ignored pulse
    issue(3'b010, 3'd7, 4'b1111, 4'b0000, 1'b0, 7, 3, 1'b0); // SHR past width, held
    issue(3'b111, 3'd6, 4'b0101, 4'b0101, 1'b0, 0, 0, 1'b0); // reserved op passes
    issue(3'b000, 3'd3, 4'b1010, 4'b1010, 1'b0, 0, 1, 1'b0); // pass
    issue(3'b001, 3'd0, 4'b1011, 4'b1011, 1'b0, 0, 0, 1'b0); // zero amount
    issue(3'b101, 3'd1, 4'b0001, 4'b1000, 1'b1, 1, 0, 1'b0); // ROR
    issue(3'b101, 3'd4, 4'b1011, 4'b1011, 1'b1, 4, 2, 1'b0); // ROR full turn
    issue(3'b011, 3'd7, 4'b0110, 4'b0000, 1'b0, 7, 0, 1'b0); // SAR to zero
    issue(3'b001, 3'd4, 4'b0111, 4'b0000, 1'b1, 4, 0, 1'b0); // SHL by width
    issue(3'b110, 3'd2, 4'b1100, 4'b1100, 1'b0, 0, 0, 1'b0); // reserved op passes
    flush();

    // Abort a ROR by 7 after four steps (three remaining)
    @(negedge clk);
    cmd_op = 3'b101; cmd_amt = 3'd7; cmd_word = 4'b1001; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("abort_pre_busy", 32'(busy), 1);
    chk("abort_pre_word", 32'(res_word), 32'(4'b1001));
    rst_n = 1'b0;
    #1;
    chk("abort_res_valid", 32'(res_valid), 0);
    chk("abort_res_word", 32'(res_word), 0);
    chk("abort_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_cmd_ready", 32'(cmd_ready), 1);
    chk("abort_idle_valid", 32'(res_valid), 0);

    issue(3'b010, 3'd2, 4'b1100, 4'b0011, 1'b0, 2, 0, 1'b0); // SHR after abort
    flush();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, datapath word width in bits.
REQ-002 SHALL have parameter CNT_W, default 3, width of the shift-amount field.
REQ-003 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port cmd_valid, input, 1, command offered.
REQ-006 SHALL have port cmd_ready, output, 1, command accepted when high with cmd_valid.
REQ-007 SHALL have port cmd_op, input, 3, operation code.
REQ-008 SHALL have port cmd_amt, input, CNT_W, shift amount 0..7.
REQ-009 SHALL have port cmd_word, input, WIDTH, operand.
REQ-010 SHALL have port res_valid, output, 1, result available.
REQ-011 SHALL have port res_ready, input, 1, consumer takes result.
REQ-012 SHALL have port res_word, output, WIDTH, shifted result.
REQ-013 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-014 SHALL decode cmd_op as: 000 pass, 001 SHL logical, 010 SHR logical, 011 SAR arithmetic, 100 ROL, 101 ROR; 110/111 pass.
REQ-015 SHALL implement FSM states IDLE, SHIFT, DONE; cmd_ready SHALL be 1 only in IDLE.
REQ-016 On accept (IDLE, cmd_valid=1): latch cmd_word, cmd_op, cmd_amt; next state SHIFT if amt>0 and op shifts, else DONE.
REQ-017 In SHIFT, each clock edge SHALL apply exactly one single-position step and decrement the remaining count; on the edge where the count reaches 0 the state SHALL become DONE.
REQ-018 Latency: accept edge E0, res_valid high after edge E0+N for N>=1, after E0 for N=0 or pass ops.
REQ-019 Logical shifts SHALL insert 0; SAR SHALL replicate the MSB; rotates SHALL wrap, so amounts >= WIDTH behave modulo-iteratively (SHL/SHR by >= WIDTH yield 0).
REQ-020 In DONE, res_valid=1 and res_word SHALL hold stable until res_valid&&res_ready, then IDLE on that edge.
REQ-021 cmd_valid while busy SHALL be ignored; no command is queued.
REQ-022 A new command SHALL NOT be accepted on the same edge a result is consumed (IDLE re-entry required first).

Reset
REQ-023 rst_n low SHALL immediately force IDLE, res_valid=0, res_word=0, busy=0, count=0, cmd_ready=1 once released, aborting any operation in progress.
REQ-024 Asynchronous assertion and synchronous release on clk.

Configuration
REQ-025 With SHIFT_SEQ_FLAGS_EN defined, outputs res_carry (last bit shifted/rotated out, 0 for N=0 or pass) and res_zero (res_word==0) SHALL exist, valid with res_valid, reset to 0.
REQ-026 Without SHIFT_SEQ_FLAGS_EN, those ports and their logic SHALL be absent; all other behaviour identical.

Structure
REQ-027 Package shift_seq_pkg SHALL hold the op-code constants and the FSM state enum typedef.
REQ-028 Single-step shift logic SHALL be sub-module shift_step (combinational: word, op -> word, carry_out).

Verification
REQ-029 word=1011, op=SHL, amt=1 -> res_valid after 1 edge, res_word=0110, carry=1.
REQ-030 word=1000, op=SAR, amt=2 -> res_word=1110 after 2 edges, carry=0.
REQ-031 word=0011, op=ROL, amt=5 -> res_word=0110 after 5 edges; cmd_valid pulsed mid-operation is ignored (cmd_ready=0).
REQ-032 word=1111, op=SHR, amt=7, res_ready held low 3 extra cycles -> res_word=0000, res_zero=1, held stable, IDLE on edge res_ready rises.
REQ-033 op=111, amt=6, word=0101 -> DONE after 1 edge, res_word=0101.
REQ-034 rst_n low during SHIFT at count 3 -> outputs 0, IDLE; next command completes normally.
